fifo_dram: RTL and testbench
============================

FIFO_DRAM -- requirements
Module: fifo_dram

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 16: number of storage entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 datain  input  WIDTH  write data.
REQ-006 wr_en  input  1  write request, sampled each rising edge.
REQ-007 rd_en  input  1  read request, sampled each rising edge.
REQ-008 dataout  output  WIDTH  registered read data.
REQ-009 empty_flag  output  1  high when the FIFO holds 0 entries.
REQ-010 full_flag  output  1  high when the FIFO holds DEPTH entries.
REQ-011 count  output  clog2(DEPTH)+1  number of stored entries.
REQ-012 overflow  output  1  one-cycle pulse when a write is rejected.
REQ-013 underflow  output  1  one-cycle pulse when a read is rejected.

Function
REQ-014 The FIFO SHALL preserve first-in first-out order of accepted writes.
REQ-015 A write SHALL be accepted when wr_en=1 and either (full_flag=0) or (full_flag=1 and an accepted read occurs in the same cycle).
- An accepted write stores datain at the write pointer and advances the pointer.
REQ-016 A read SHALL be accepted when rd_en=1 and empty_flag=0.
- An accepted read loads the entry at the read pointer into dataout on the same edge, so data is visible one cycle after rd_en is sampled.
- The read pointer then advances.
REQ-017 dataout SHALL hold its previous value in every cycle without an accepted read.
REQ-018 With wr_en=1 and rd_en=1 while empty, only the write SHALL occur: no bypass to dataout, and underflow pulses.
REQ-019 With wr_en=1 and rd_en=1 while neither empty nor full, both SHALL occur and count SHALL be unchanged.
REQ-020 The read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 count SHALL increment on a write-only cycle, decrement on a read-only cycle, and hold otherwise; it SHALL never exceed DEPTH or go below 0.
REQ-022 empty_flag and full_flag SHALL be registered, or derived combinationally from the registered count, and SHALL be valid in the cycle after the edge that changes count.
REQ-023 overflow SHALL be 1 for exactly the cycle following an edge where wr_en=1 and the write was rejected; underflow likewise for a rejected read.
REQ-024 Rejected operations SHALL NOT change the pointers, count, memory or dataout.

Reset
REQ-025 While rst=1 at a rising edge, the next state SHALL be:
- pointers=0, count=0, empty_flag=1, full_flag=0
- dataout=0, overflow=0, underflow=0
REQ-026 rst SHALL take priority over wr_en and rd_en in the same cycle; mid-operation reset discards all stored data.
REQ-027 Memory contents need not be cleared by reset.

Structure
REQ-028 A shared package fifo_dram_pkg SHALL hold the WIDTH/DEPTH defaults and the derived pointer and count widths.
REQ-029 Storage SHALL be a sub-module fifo_dram_mem: a DEPTH x WIDTH register array with one synchronous write port and one synchronous read port.
REQ-030 Pointer, count, flag and error logic SHALL reside in fifo_dram.

Verification
REQ-031 Reset with rd_en=1 held, then release with no writes -> empty_flag=1, full_flag=0, count=0, dataout=0x00, underflow pulses each cycle rd_en=1.
REQ-032 Write 0x00,0x01,0x02,0x03,0x04 on consecutive edges (rd_en=0) -> count=5, empty_flag=0 after the first write.
- Then rd_en=1 -> dataout 0x00..0x04 in order, each one cycle after its read.
- empty_flag=1 after the fifth read.
REQ-033 Write 16 words 0x10..0x1F -> full_flag=1, count=16.
- A 17th write 0xAA -> overflow pulse, contents unchanged.
- Reading 16 words -> 0x10..0x1F in order.
REQ-034 Simultaneous rd_en/wr_en:
- When full -> count stays 16, oldest word returned, new word stored.
- When empty -> count becomes 1, dataout unchanged.
REQ-035 Wrap-around: repeatedly write 10 and read 10 for 4 rounds -> all 40 words returned in order with no flag errors.
REQ-036 Assert rst with count=7 -> next cycle count=0, empty_flag=1, dataout=0x00; a following read pulses underflow.

Source files
------------

// File: rtl/fifo_dram_pkg.sv
// Shared definitions for the fifo_dram block.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and entry count
//   DEFAULT_PTR_W / DEFAULT_CNT_W : pointer and occupancy-count widths at the defaults
//   ptr_width()                   : pointer width for an arbitrary power-of-two depth
package fifo_dram_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Pointers index DEPTH entries; the count needs one extra bit to represent DEPTH itself.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int DEFAULT_PTR_W = ptr_width(DEFAULT_DEPTH);
  localparam int DEFAULT_CNT_W = DEFAULT_PTR_W + 1;

endpackage

// File: rtl/fifo_dram_mem.sv
// Storage array for fifo_dram: DEPTH x WIDTH registers, one synchronous write
// port and one synchronous (registered) read port.
//   clk, rst         : clock and synchronous active-high reset (clears read register only)
//   wr_en/wr_addr/wr_data : write port, committed on the rising edge
//   rd_en/rd_addr    : read port; rd_data loads mem[rd_addr] on the edge rd_en is high
//   rd_data          : registered read data, held when rd_en is low
module fifo_dram_mem
  import fifo_dram_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  // Contents are deliberately not reset so the array can map onto RAM primitives.
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Read-before-write: when both ports hit the same entry (FIFO full with a
  // simultaneous read and write) the old word is returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/fifo_dram.sv
// Synchronous single-clock FIFO with registered read data.
//   clk, rst     : clock and synchronous active-high reset
//   datain/wr_en : write data and write request
//   rd_en        : read request; dataout updates on the edge that accepts the read
//   dataout      : registered read data, held between accepted reads
//   empty_flag, full_flag : occupancy flags decoded from the registered count
//   count        : number of stored entries (0..DEPTH)
//   overflow, underflow   : one-cycle pulses after a rejected write / read
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module fifo_dram
  import fifo_dram_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       datain,
  input  logic                   wr_en,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       dataout,
  output logic                   empty_flag,
  output logic                   full_flag,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic             rd_accept;
  logic             wr_accept;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (count_reg == '0);
  assign is_full  = (count_reg == CNT_W'(DEPTH));

  // A read frees a slot in the same edge, so a full FIFO can still take a
  // write when it is also being read. An empty FIFO never bypasses.
  assign rd_accept = rd_en && !is_empty;
  assign wr_accept = wr_en && (!is_full || rd_accept);

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = wr_en && !wr_accept;
    underflow_next = rd_en && !rd_accept;

    // Pointer width equals log2(DEPTH), so increment wraps DEPTH-1 -> 0.
    if (wr_accept) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (rd_accept) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Memory writes are gated off during reset so a reset cycle never disturbs storage.
  fifo_dram_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept && !rst),
    .wr_addr (wr_ptr_reg),
    .wr_data (datain),
    .rd_en   (rd_accept && !rst),
    .rd_addr (rd_ptr_reg),
    .rd_data (dataout)
  );

  assign empty_flag = is_empty;
  assign full_flag  = is_full;
  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign underflow  = underflow_reg;

endmodule

// File: tb/tb_fifo_dram.sv
// Self-checking bench for fifo_dram (WIDTH=8, DEPTH=16): a table of directed
// vectors for reset/basic ordering/empty corner cases, then hand-written
// sequences for full, simultaneous access, wrap-around and mid-run reset.
module tb_fifo_dram;

  logic       clk;
  logic       rst;
  logic [7:0] datain;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] dataout;
  logic       empty_flag;
  logic       full_flag;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;
  int step_no = 0;
  logic [7:0] last_dout;

  fifo_dram #(
    .WIDTH (8),
    .DEPTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .datain     (datain),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dataout    (dataout),
    .empty_flag (empty_flag),
    .full_flag  (full_flag),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       w;
    logic       rd;
    logic [7:0] din;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic [7:0] dout;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step_no, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare every output 1 time unit later.
  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] din,
                      input logic [4:0] cnt, input logic emp, input logic ful,
                      input logic [7:0] dout, input logic ovf, input logic unf);
    rst    = r;
    wr_en  = w;
    rd_en  = rd;
    datain = din;
    @(posedge clk);
    #1;
    check("count",     32'(count),      32'(cnt));
    check("empty",     32'(empty_flag), 32'(emp));
    check("full",      32'(full_flag),  32'(ful));
    check("dataout",   32'(dataout),    32'(dout));
    check("overflow",  32'(overflow),   32'(ovf));
    check("underflow", 32'(underflow),  32'(unf));
    $display("step %0d rst=%0d wr=%0d rd=%0d din=%02h -> count=%0d e=%0d f=%0d dout=%02h ovf=%0d unf=%0d",
             step_no, r, w, rd, din, count, empty_flag, full_flag, dataout, overflow, underflow);
    step_no++;
  endtask

  task automatic av(input logic r, input logic w, input logic rd, input logic [7:0] din,
                    input logic [4:0] cnt, input logic emp, input logic ful,
                    input logic [7:0] dout, input logic ovf, input logic unf);
    vec_t v;
    v.r = r; v.w = w; v.rd = rd; v.din = din; v.cnt = cnt;
    v.emp = emp; v.ful = ful; v.dout = dout; v.ovf = ovf; v.unf = unf;
    vq.push_back(v);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; datain = 8'h00;

    // Reset with rd_en held, then release with no writes: underflow each read cycle.
    av(1'b1, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    av(1'b1, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    av(1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    av(1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    av(1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    // Five writes then five reads in order.
    av(1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    av(1'b0, 1'b1, 1'b0, 8'h01, 5'd2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    av(1'b0, 1'b1, 1'b0, 8'h02, 5'd3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    av(1'b0, 1'b1, 1'b0, 8'h03, 5'd4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    av(1'b0, 1'b1, 1'b0, 8'h04, 5'd5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    av(1'b0, 1'b0, 1'b1, 8'h00, 5'd4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    av(1'b0, 1'b0, 1'b1, 8'h00, 5'd3, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
    av(1'b0, 1'b0, 1'b1, 8'h00, 5'd2, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
    av(1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
    av(1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0);
    // Read while empty: rejected, dataout held.
    av(1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 8'h04, 1'b0, 1'b1);
    // Simultaneous read/write while empty: write only, no bypass, underflow.
    av(1'b0, 1'b1, 1'b1, 8'h55, 5'd1, 1'b0, 1'b0, 8'h04, 1'b0, 1'b1);
    av(1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);

    foreach (vq[i]) begin
      step(vq[i].r, vq[i].w, vq[i].rd, vq[i].din, vq[i].cnt,
           vq[i].emp, vq[i].ful, vq[i].dout, vq[i].ovf, vq[i].unf);
    end
    last_dout = 8'h55;

    // Fill to 16, attempt a 17th write, then drain in order.
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 1'b0, 8'(8'h10 + i), 5'(i + 1), 1'b0, (i == 15), last_dout, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'hAA, 5'd16, 1'b0, 1'b1, last_dout, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 5'd16, 1'b0, 1'b1, last_dout, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      last_dout = 8'(8'h10 + i);
      step(1'b0, 1'b0, 1'b1, 8'h00, 5'(15 - i), (i == 15), 1'b0, last_dout, 1'b0, 1'b0);
    end

    // Refill, then simultaneous read/write while full: oldest out, new word in.
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i), 5'(i + 1), 1'b0, (i == 15), last_dout, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'hBB, 5'd16, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      last_dout = (i < 15) ? 8'(8'h21 + i) : 8'hBB;
      step(1'b0, 1'b0, 1'b1, 8'h00, 5'(15 - i), (i == 15), 1'b0, last_dout, 1'b0, 1'b0);
    end

    // Wrap-around: four rounds of 10 writes and 10 reads.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 10; i++)
        step(1'b0, 1'b1, 1'b0, 8'(8'h40 + r * 10 + i), 5'(i + 1), 1'b0, 1'b0, last_dout, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
        last_dout = 8'(8'h40 + r * 10 + i);
        step(1'b0, 1'b0, 1'b1, 8'h00, 5'(9 - i), (i == 9), 1'b0, last_dout, 1'b0, 1'b0);
      end
    end

    // Mid-run reset with count=7 and non-zero dataout; reset wins over wr/rd.
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i), 5'(i + 1), 1'b0, 1'b0, last_dout, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h00, 5'd7, 1'b0, 1'b0, 8'h60, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'hCC, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
